tm1638_key_events: RTL and testbench
====================================

Name: tm1638_key_events

Overview:
Downstream consumer of the TM1638 controller's 4-byte key-scan output (`tm1638_in`). It samples the raw scan bytes periodically and debounces each key of the LED&KEY board (8 keys). It produces a stable key vector, one-cycle press/release pulses, and a ready/valid queue of key events for a CPU or other application logic. Single clock domain, same clock as the TM1638 controller.

Parameters:
- SAMPLE_PERIOD, 32'd250_000, clocks between raw samples (5 ms at 50 MHz); must be >= 16.
- DEBOUNCE_COUNT, 3, consecutive differing samples needed to accept a key change; range 1..15.
- EVENT_DEPTH, 8, event FIFO depth; power of two, >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tm1638_in  in  [7:0] x 4 (unpacked [4])  raw key-scan bytes from the TM1638 controller
- keys  out  8  debounced key state, 1 = pressed
- key_pressed  out  8  one-cycle pulse per key on accepted press
- key_released  out  8  one-cycle pulse per key on accepted release
- event_valid  out  1  FIFO head valid
- event_ready  in  1  consumer accepts head
- event_key  out  3  key index of head event
- event_press  out  1  1 = press, 0 = release
- overflow  out  1  sticky; an event was dropped
- overflow_clear  in  1  clears overflow

Behaviour:
- Key mapping, with k in 0..3:
  - key k = `tm1638_in[k][0]`
  - key k+4 = `tm1638_in[k][4]`
  - all other bits are ignored.
- Reset (async assert, values apply immediately):
  - keys = 0, pulses = 0, overflow = 0, FIFO empty (event_valid = 0).
  - All debounce counters = 0; pending mask = 0; scanner state S_IDLE.
  - Sample counter = SAMPLE_PERIOD-1.
- Sample tick:
  - The sample counter decrements every cycle.
  - At 0 it asserts `tick` for one cycle and reloads SAMPLE_PERIOD-1.
  - First tick occurs SAMPLE_PERIOD cycles after reset deasserts.
- Debounce, per key, on each tick:
  - raw == keys[i]: counter resets to 0.
  - raw != keys[i] and counter == DEBOUNCE_COUNT-1: keys[i] toggles, counter goes to 0, the matching pulse asserts, and pending[i] is set.
  - raw != keys[i] otherwise: counter increments.
  - keys and pulses are registered and visible the cycle after the tick.
  - With DEBOUNCE_COUNT = 1, a key changes on the first differing tick.
  - Pulses are 0 on all non-tick cycles.
- Event serializer FSM:
  - S_IDLE: when pending != 0, go to S_SCAN.
  - S_SCAN: each cycle, take the lowest set pending bit i, clear it, and push {i, keys[i]} into the FIFO.
    - When pending becomes 0, return to S_IDLE.
    - At most 8 cycles per tick; SAMPLE_PERIOD >= 16 guarantees pending is empty before the next tick.
- FIFO:
  - Push when full: the event is dropped and overflow is set the next cycle.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - event_valid = !empty; head data is stable while valid && !ready.
  - Pop on valid && ready; first-word latency is 1 cycle from push to event_valid.
- overflow_clear and a drop in the same cycle: overflow stays set (set wins).
- Reset mid-operation: FIFO contents, pending events, and partial debounce progress are discarded.
- The 2-sample-period latency minimum (press to event) equals DEBOUNCE_COUNT ticks + 1 cycle + the serializer slot.

Decomposition:
- Package `tm1638_pkg`:
  - `TM1638_IN_COUNT` = 4, `NUM_KEYS` = 8.
  - typedef `key_event_t` = struct packed {logic [2:0] key; logic press;}.
  - Scanner state enum {S_IDLE, S_SCAN}.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; full/empty, push/pop), instantiated once with WIDTH = `$bits(key_event_t)`.

Test Plan:
All scenarios use SAMPLE_PERIOD = 16 and DEBOUNCE_COUNT = 3.
1. Reset, then hold all inputs 0 for 200 cycles -> keys = 0, no pulses, event_valid = 0, overflow = 0.
2. Set `tm1638_in[2][0]` = 1 and hold, with event_ready = 1 -> at the 3rd tick, keys = 8'h04 and key_pressed = 8'h04 for exactly 1 cycle; one event {key = 2, press = 1}. Clear the bit -> 3 ticks later, one release event {2, 0}.
3. Bounce: toggle `tm1638_in[1][4]` every tick for 10 ticks, then hold 1 -> no change before it is stable for 3 ticks; exactly one press event, key = 5.
4. Press all 8 keys simultaneously (bytes = 8'h11) -> 8 press events in key order 0..7 on consecutive cycles; keys = 8'hFF.
5. event_ready = 0, generate 10 press/release events -> 8 queued; overflow = 1 after the 9th. Raise overflow_clear with no drop -> overflow = 0. Drain -> the first 8 events in order.
6. Assert reset asynchronously mid-debounce (counter = 2) and with the FIFO holding 3 events -> immediately event_valid = 0 and keys = 0; after release, a full 3 ticks are needed to re-accept the key.

Source files
------------

// File: rtl/tm1638_pkg.sv
// Shared types and constants for the TM1638 key-event path: key counts, the
// event record pushed into the FIFO, and the serializer state encoding.
package tm1638_pkg;

   localparam int TM1638_IN_COUNT = 4;
   localparam int NUM_KEYS        = 8;

   typedef struct packed {
      logic [2:0] key;
      logic       press;
   } key_event_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } scan_state_e;

   // Index of the lowest set bit; the caller only uses it when mask != 0.
   function automatic logic [2:0] lowestSet(input logic [NUM_KEYS-1:0] mask);
      logic [2:0] idx;
      idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (mask[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers. A push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle; otherwise drop_o.
module sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             drop_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wrPtr_q, rdPtr_q;
   logic             doPush, doPop;

   assign empty_o = (wrPtr_q == rdPtr_q);
   assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                    (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign doPop   = pop_i && !empty_o;
   assign doPush  = push_i && (!full_o || doPop);
   assign drop_o  = push_i && !doPush;
   assign data_o  = mem_q[rdPtr_q[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + {{AW{1'b0}}, 1'b1};
         if (doPop)  rdPtr_q <= rdPtr_q + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/tm1638_key_events.sv
// Debounces the eight LED&KEY buttons from the TM1638 scan bytes and turns
// accepted changes into pulses plus a ready/valid queue of key events.
module tm1638_key_events
   import tm1638_pkg::*;
#(
   parameter int unsigned SAMPLE_PERIOD  = 32'd250_000,
   parameter int          DEBOUNCE_COUNT = 3,
   parameter int          EVENT_DEPTH    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          tm1638_in [TM1638_IN_COUNT],
   output logic [NUM_KEYS-1:0] keys,
   output logic [NUM_KEYS-1:0] key_pressed,
   output logic [NUM_KEYS-1:0] key_released,
   output logic                event_valid,
   input  logic                event_ready,
   output logic [2:0]          event_key,
   output logic                event_press,
   output logic                overflow,
   input  logic                overflow_clear
);

   localparam logic [31:0] RELOAD  = 32'(SAMPLE_PERIOD - 1);
   localparam logic [3:0]  DB_LAST = 4'(DEBOUNCE_COUNT - 1);

   logic [31:0]         sampleCnt_q;
   logic                tick;
   logic [NUM_KEYS-1:0] raw;
   logic                unusedInBits;
   logic [NUM_KEYS-1:0] keys_q, pressed_q, released_q, pending_q;
   logic [NUM_KEYS-1:0] keys_d, pressed_d, released_d, pending_d;
   logic [NUM_KEYS-1:0] accepted, pendingClr;
   logic [3:0]          dbCnt_q [NUM_KEYS];
   logic [3:0]          dbCnt_d [NUM_KEYS];
   scan_state_e         state_q, state_d;
   logic [2:0]          slot;
   logic                push, drop, unusedFull, fifoEmpty;
   key_event_t          pushEvt, headEvt;
   logic                overflow_q, overflow_d;

   assign tick = (sampleCnt_q == 32'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sampleCnt_q <= RELOAD;
      else       sampleCnt_q <= tick ? RELOAD : sampleCnt_q - 32'd1;
   end

   // Keys live in bits 0 and 4 of each scan byte; the rest is board-specific.
   always_comb begin
      raw          = '0;
      unusedInBits = 1'b0;
      for (int k = 0; k < TM1638_IN_COUNT; k++) begin
         raw[k]       = tm1638_in[k][0];
         raw[k+4]     = tm1638_in[k][4];
         unusedInBits = unusedInBits ^ (^{tm1638_in[k][7:5], tm1638_in[k][3:1]});
      end
   end

   always_comb begin
      dbCnt_d  = dbCnt_q;
      accepted = '0;
      if (tick) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (raw[i] == keys_q[i]) begin
               dbCnt_d[i] = '0;
            end else if (dbCnt_q[i] == DB_LAST) begin
               dbCnt_d[i]  = '0;
               accepted[i] = 1'b1;
            end else begin
               dbCnt_d[i] = dbCnt_q[i] + 4'd1;
            end
         end
      end
      keys_d     = keys_q ^ accepted;
      pressed_d  = accepted & ~keys_q;
      released_d = accepted & keys_q;
   end

   // One pending key is serialized per cycle, lowest index first.
   always_comb begin
      state_d    = state_q;
      pendingClr = '0;
      push       = 1'b0;
      slot       = lowestSet(pending_q);
      pushEvt    = '{key: slot, press: keys_q[slot]};
      case (state_q)
         S_IDLE: if (pending_q != '0) state_d = S_SCAN;
         S_SCAN: begin
            if (pending_q != '0) begin
               pendingClr[slot] = 1'b1;
               push             = 1'b1;
            end
            if ((pending_q & ~pendingClr) == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      pending_d = (pending_q & ~pendingClr) | accepted;
   end

   always_comb begin
      overflow_d = overflow_q;
      if (drop)                overflow_d = 1'b1;
      else if (overflow_clear) overflow_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         keys_q     <= '0;
         pressed_q  <= '0;
         released_q <= '0;
         pending_q  <= '0;
         state_q    <= S_IDLE;
         overflow_q <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) dbCnt_q[i] <= '0;
      end else begin
         keys_q     <= keys_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
         pending_q  <= pending_d;
         state_q    <= state_d;
         overflow_q <= overflow_d;
         dbCnt_q    <= dbCnt_d;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(key_event_t)),
      .DEPTH (EVENT_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .data_i  (pushEvt),
      .pop_i   (event_ready),
      .data_o  (headEvt),
      .full_o  (unusedFull),
      .empty_o (fifoEmpty),
      .drop_o  (drop)
   );

   assign keys         = keys_q;
   assign key_pressed  = pressed_q;
   assign key_released = released_q;
   assign event_valid  = !fifoEmpty;
   assign event_key    = headEvt.key;
   assign event_press  = headEvt.press;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_tm1638_key_events.sv
// Directed bench for tm1638_key_events: a sample-history key model plus an
// event scoreboard checked every cycle, with literal checkpoints per scenario.
module tb_tm1638_key_events;

   localparam int P     = 16;
   localparam int D     = 3;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tmIn [4];
   logic       eventReady = 1'b0;
   logic       overflowClear = 1'b0;
   logic [7:0] keys, keyPressed, keyReleased;
   logic       eventValid, eventPress, overflow;
   logic [2:0] eventKey;

   int checks = 0;
   int fails = 0;

   tm1638_key_events #(
      .SAMPLE_PERIOD  (P),
      .DEBOUNCE_COUNT (D),
      .EVENT_DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .tm1638_in      (tmIn),
      .keys           (keys),
      .key_pressed    (keyPressed),
      .key_released   (keyReleased),
      .event_valid    (eventValid),
      .event_ready    (eventReady),
      .event_key      (eventKey),
      .event_press    (eventPress),
      .overflow       (overflow),
      .overflow_clear (overflowClear)
   );

   always #5 clk = ~clk;

   // Model state: per-key history of the last D samples and samples since the last change
   logic [7:0]   mKeys = '0, mPressed = '0, mReleased = '0, mRaw;
   logic [D-1:0] hist [8];
   int           sinceChange [8];
   int           edgesSinceReset = 0;
   int           tickCount = 0;
   int           cyc = 0;
   int           pressPulseCycles = 0;
   logic         mOverflow = 1'b0;
   logic [3:0]   expQ [$];
   logic [3:0]   logEvt [$];
   int           logCyc [$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // A key changes once its last D samples all disagree with it and all D came after its previous change.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mKeys = '0; mPressed = '0; mReleased = '0;
         edgesSinceReset = 0;
         mOverflow = 1'b0;
         expQ.delete();
         for (int i = 0; i < 8; i++) begin
            hist[i] = '0;
            sinceChange[i] = 0;
         end
      end else begin
         edgesSinceReset++;
         mPressed = '0;
         mReleased = '0;
         if (overflowClear) mOverflow = 1'b0;
         if (edgesSinceReset % P == 0) begin
            tickCount++;
            for (int k = 0; k < 4; k++) begin
               mRaw[k]   = tmIn[k][0];
               mRaw[k+4] = tmIn[k][4];
            end
            for (int i = 0; i < 8; i++) begin
               hist[i] = {hist[i][D-2:0], mRaw[i]};
               sinceChange[i]++;
               if (sinceChange[i] >= D && hist[i] == {D{~mKeys[i]}}) begin
                  mKeys[i] = ~mKeys[i];
                  if (mKeys[i]) mPressed[i] = 1'b1;
                  else          mReleased[i] = 1'b1;
                  sinceChange[i] = 0;
                  if (expQ.size() >= DEPTH) mOverflow = 1'b1;
                  else expQ.push_back({3'(i), mKeys[i]});
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         checkOutput("keys", 32'(keys), 32'(mKeys));
         checkOutput("keyPressed", 32'(keyPressed), 32'(mPressed));
         checkOutput("keyReleased", 32'(keyReleased), 32'(mReleased));
         if (keyPressed[2]) pressPulseCycles++;
         if (eventValid && eventReady) begin
            if (expQ.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpectedEvent: got key %0d press %0d, expected no event", eventKey, eventPress);
            end else begin
               checkOutput("eventHead", 32'({eventKey, eventPress}), 32'(expQ.pop_front()));
            end
            logEvt.push_back({eventKey, eventPress});
            logCyc.push_back(cyc);
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
      tmIn[0] = b0; tmIn[1] = b1; tmIn[2] = b2; tmIn[3] = b3;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic waitTicks(input int n);
      int target;
      int budget;
      target = tickCount + n;
      budget = n * P + 4;
      while (tickCount < target && budget > 0) begin
         @(posedge clk);
         #2;
         budget--;
      end
      if (tickCount < target) checkOutput("tickTimeout", 32'(tickCount), 32'(target));
   endtask

   int logStart;

   initial begin
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00);
      repeat (3) @(posedge clk);
      #2;
      checkOutput("resetKeys", 32'(keys), 32'h0);
      checkOutput("resetValid", 32'(eventValid), 32'h0);
      checkOutput("resetOverflow", 32'(overflow), 32'h0);
      @(negedge clk);
      #1 reset = 1'b0;

      $display("[TB] Scenario 1: idle after reset");
      waitCycles(200);
      checkOutput("idleKeys", 32'(keys), 32'h0);
      checkOutput("idlePressed", 32'(keyPressed), 32'h0);
      checkOutput("idleValid", 32'(eventValid), 32'h0);
      checkOutput("idleOverflow", 32'(overflow), 32'h0);

      $display("[TB] Scenario 2: single press and release of key 2");
      eventReady = 1'b1;
      waitTicks(1);
      logStart = logEvt.size();
      applyStimulus(8'h00, 8'h00, 8'h01, 8'h00);
      waitTicks(2);
      checkOutput("key2NotYet", 32'(keys), 32'h00);
      waitTicks(1);
      checkOutput("key2Keys", 32'(keys), 32'h04);
      checkOutput("key2Pulse", 32'(keyPressed), 32'h04);
      waitCycles(1);
      checkOutput("key2PulseGone", 32'(keyPressed), 32'h00);
      waitCycles(10);
      checkOutput("key2PulseCycles", 32'(pressPulseCycles), 32'd1);
      checkOutput("key2EventCount", 32'(logEvt.size() - logStart), 32'd1);
      if (logEvt.size() > logStart) checkOutput("key2PressEvt", 32'(logEvt[logStart]), 32'b0101);
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00);
      waitTicks(3);
      checkOutput("key2Released", 32'(keyReleased), 32'h04);
      waitCycles(10);
      checkOutput("key2EventCount2", 32'(logEvt.size() - logStart), 32'd2);
      if (logEvt.size() > logStart + 1) checkOutput("key2RelEvt", 32'(logEvt[logStart+1]), 32'b0100);

      $display("[TB] Scenario 3: bouncing key 5");
      logStart = logEvt.size();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(8'h00, (i % 2 == 0) ? 8'h10 : 8'h00, 8'h00, 8'h00);
         waitTicks(1);
      end
      checkOutput("bounceKeys", 32'(keys), 32'h00);
      applyStimulus(8'h00, 8'h10, 8'h00, 8'h00);
      waitTicks(2);
      checkOutput("bounceNotYet", 32'(keys), 32'h00);
      waitTicks(1);
      checkOutput("bounceAccepted", 32'(keys), 32'h20);
      waitCycles(10);
      checkOutput("bounceEventCount", 32'(logEvt.size() - logStart), 32'd1);
      if (logEvt.size() > logStart) checkOutput("bounceEvt", 32'(logEvt[logStart]), 32'b1011);
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00);
      waitTicks(3);
      waitCycles(10);
      checkOutput("key5Released", 32'(keys), 32'h00);

      $display("[TB] Scenario 4: all keys at once");
      logStart = logEvt.size();
      applyStimulus(8'h11, 8'h11, 8'h11, 8'h11);
      waitTicks(3);
      checkOutput("allKeys", 32'(keys), 32'hFF);
      checkOutput("allPulse", 32'(keyPressed), 32'hFF);
      waitCycles(14);
      checkOutput("allEventCount", 32'(logEvt.size() - logStart), 32'd8);
      if (logEvt.size() >= logStart + 8) begin
         for (int j = 0; j < 8; j++) checkOutput("allEvtOrder", 32'(logEvt[logStart+j]), 32'((j << 1) | 1));
         for (int j = 1; j < 8; j++) checkOutput("allEvtSpacing", 32'(logCyc[logStart+j] - logCyc[logStart+j-1]), 32'd1);
      end
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00);
      waitTicks(3);
      waitCycles(14);
      checkOutput("allReleased", 32'(keys), 32'h00);

      $display("[TB] Scenario 5: overflow with a stalled consumer");
      eventReady = 1'b0;
      logStart = logEvt.size();
      applyStimulus(8'h11, 8'h01, 8'h01, 8'h01);
      waitTicks(3);
      waitCycles(12);
      checkOutput("ovfValid", 32'(eventValid), 32'h1);
      checkOutput("ovfNotYet", 32'(overflow), 32'h0);
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00);
      waitTicks(3);
      waitCycles(12);
      checkOutput("ovfSet", 32'(overflow), 32'h1);
      checkOutput("ovfModel", 32'(overflow), 32'(mOverflow));
      overflowClear = 1'b1;
      waitCycles(1);
      overflowClear = 1'b0;
      checkOutput("ovfCleared", 32'(overflow), 32'h0);
      eventReady = 1'b1;
      waitCycles(12);
      checkOutput("drainCount", 32'(logEvt.size() - logStart), 32'd8);
      if (logEvt.size() >= logStart + 8) begin
         checkOutput("drainFirst", 32'(logEvt[logStart]), 32'b0001);
         checkOutput("drainLast", 32'(logEvt[logStart+7]), 32'b0100);
      end
      checkOutput("drainEmpty", 32'(eventValid), 32'h0);

      $display("[TB] Scenario 6: asynchronous reset mid-debounce");
      eventReady = 1'b0;
      logStart = logEvt.size();
      applyStimulus(8'h01, 8'h01, 8'h01, 8'h00);
      waitTicks(3);
      waitCycles(12);
      checkOutput("preResetValid", 32'(eventValid), 32'h1);
      applyStimulus(8'h00, 8'h01, 8'h01, 8'h00);
      waitTicks(2);
      #1 reset = 1'b1;
      #1;
      checkOutput("asyncValid", 32'(eventValid), 32'h0);
      checkOutput("asyncKeys", 32'(keys), 32'h00);
      checkOutput("asyncOverflow", 32'(overflow), 32'h0);
      @(negedge clk);
      #1 reset = 1'b0;
      eventReady = 1'b1;
      waitTicks(2);
      checkOutput("reacqNotYet", 32'(keys), 32'h00);
      waitTicks(1);
      checkOutput("reacqKeys", 32'(keys), 32'h06);
      waitCycles(12);
      checkOutput("reacqEventCount", 32'(logEvt.size() - logStart), 32'd2);
      if (logEvt.size() >= logStart + 2) begin
         checkOutput("reacqEvt0", 32'(logEvt[logStart]), 32'b0011);
         checkOutput("reacqEvt1", 32'(logEvt[logStart+1]), 32'b0101);
      end
      checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
